// File: rtl/ex_shift_pkg.sv
// ex_shift_pkg: shared types and default widths for the execute-stage shift pipe
package ex_shift_pkg;
  localparam int DW_DEF = 8;
  localparam int CW_DEF = 4;
  localparam int TAGW_DEF = 5;
  typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA, SH_ROR} shift_op_t;
  typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_TWO} occ_state_t;
endpackage

// File: rtl/ex_shift_stage_shift_core.sv
// shift_core: combinational SLL/SRL/SRA/ROR; linear shifts by n>=DW give zero, ROR wraps n mod DW
module shift_core
  import ex_shift_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  shift_op_t       i_op,
  input  logic [DW-1:0]   i_a,
  input  logic [CW-1:0]   i_n,
  output logic [DW-1:0]   o_res
);
  logic            w_big;
  logic [DW-1:0]   w_sra;
  logic [2*DW-1:0] w_rot;
  assign w_big = 32'(i_n) >= DW;
  assign w_sra = $signed(i_a) >>> i_n;
  assign w_rot = {i_a, i_a} >> (32'(i_n) % DW);
  always_comb begin
    o_res = i_op == SH_ROR ? w_rot[DW-1:0] :
            w_big          ? '0 :
            i_op == SH_SLL ? i_a << i_n :
            i_op == SH_SRL ? i_a >> i_n : w_sra;
  end
endmodule

// File: rtl/ex_shift_stage.sv
// ex_shift_stage: registered shift pipe with 2-entry skid buffer and flush.
// Optional flag outputs out_zero/out_neg when EX_SHIFT_FLAGS_EN is defined.
module ex_shift_stage
  import ex_shift_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int CW   = CW_DEF,
  parameter int TAGW = TAGW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [DW-1:0]   in_a,
  input  logic [DW-1:0]   in_b,
  input  logic [TAGW-1:0] in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
`ifdef EX_SHIFT_FLAGS_EN
  output logic            out_zero,
  output logic            out_neg,
`endif
  output logic [TAGW-1:0] out_rd
);
`ifdef EX_SHIFT_FLAGS_EN
  localparam int PW = DW + TAGW + 2;
`else
  localparam int PW = DW + TAGW;
`endif
  occ_state_t    r_state;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [PW-1:0] r_out;
  logic [PW-1:0] r_skid;
  logic [DW-1:0] w_res;
  logic [PW-1:0] w_pay;
  logic          w_acc;
  logic          w_drain;
  logic          w_unused_b;
  shift_core #(.DW(DW), .CW(CW)) u_core (
    .i_op (shift_op_t'(in_op)),
    .i_a  (in_a),
    .i_n  (in_b[CW-1:0]),
    .o_res(w_res)
  );
  assign w_unused_b = ^in_b;
`ifdef EX_SHIFT_FLAGS_EN
  assign w_pay    = {w_res == '0, w_res[DW-1], in_rd, w_res};
  assign out_zero = r_out[PW-1];
  assign out_neg  = r_out[PW-2];
`else
  assign w_pay = {in_rd, w_res};
`endif
  assign w_acc     = in_valid & r_in_ready;
  assign w_drain   = r_out_valid & out_ready;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out[DW-1:0];
  assign out_rd    = r_out[DW+TAGW-1:DW];
  // flush keeps the data registers so outputs never change to garbage while invalid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= OCC_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_skid      <= '0;
    end else if (flush) begin
      r_state     <= OCC_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        OCC_EMPTY: if (w_acc) begin
          r_out       <= w_pay;
          r_out_valid <= 1'b1;
          r_state     <= OCC_ONE;
        end
        OCC_ONE: if (w_acc && !w_drain) begin
          r_skid     <= w_pay;
          r_in_ready <= 1'b0;
          r_state    <= OCC_TWO;
        end else if (w_acc) begin
          r_out <= w_pay;
        end else if (w_drain) begin
          r_out_valid <= 1'b0;
          r_state     <= OCC_EMPTY;
        end
        OCC_TWO: if (w_drain) begin
          r_out      <= r_skid;
          r_in_ready <= 1'b1;
          r_state    <= OCC_ONE;
        end
        default: r_state <= OCC_EMPTY;
      endcase
    end
  end
endmodule
